// File: rtl/cordic_pkg.sv
// Shared CORDIC constants for wrappers around cordic_iter_core: gain, 64-bit arctangent
// table (full turn = 2^64) and a helper that rounds a table entry to a narrower angle width.
`timescale 1ns/1ps
package cordic_pkg;

    // CORDIC gain K = prod(1/sqrt(1+2^-2i)) scaled by 2^63.
    localparam logic [63:0] CORDIC_GAIN = 64'h4DBA_76D4_21AF_2D34;

    // 1/(2*pi) as a 128-bit binary fraction.
    localparam logic [127:0] INV_2PI = 128'h28BE_60DB_9391_054A_7F09_D5F4_7D4D_3770;

    // atan(2^-i) in turns scaled by 2^64; Taylor series evaluated in Q120, then converted.
    function automatic logic [63:0] atan_turns(input int i);
        logic [127:0] term;
        logic [127:0] sum;
        logic [255:0] prod;
        if (i == 0) begin
            return 64'h2000_0000_0000_0000;
        end
        term = 128'd1 << (120 - i);
        sum  = '0;
        for (int k = 0; k < 64 && term != '0; k++) begin
            if (k[0]) begin
                sum = sum - term / 128'(2 * k + 1);
            end else begin
                sum = sum + term / 128'(2 * k + 1);
            end
            term = term >> (2 * i);
        end
        prod = {128'd0, sum} * {128'd0, INV_2PI};
        prod = prod + (256'd1 << 183);
        return prod[247:184];
    endfunction

    function automatic logic [63:0][63:0] build_lut();
        logic [63:0][63:0] lut;
        for (int i = 0; i < 64; i++) begin
            lut[i] = atan_turns(i);
        end
        return lut;
    endfunction

    localparam logic [63:0][63:0] CORDIC_LUT = build_lut();

    // Entry i rounded half-up to a width-bit angle (right-aligned in the result).
    function automatic logic [63:0] cordic_angle(input int i, input int width);
        logic [64:0] r;
        if (width >= 64) begin
            return CORDIC_LUT[i];
        end
        r = {1'b0, CORDIC_LUT[i]} + (65'd1 << (63 - width));
        return r[63:0] >> (64 - width) | (r[64] ? (64'd1 << width) : 64'd0);
    endfunction

endpackage

// File: rtl/cordic_rotate.sv
// Combinational CORDIC micro-rotation: one shift-add step in rotation mode,
// steering toward z = 0. Reused by unregistered variants.
`timescale 1ns/1ps
module cordic_rotate #(
    parameter int WIDTH = 16,
    parameter int SHW   = 4
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] z,
    input  logic [SHW-1:0]   shift,
    input  logic [WIDTH-1:0] alpha,
    output logic [WIDTH-1:0] x_rot,
    output logic [WIDTH-1:0] y_rot,
    output logic [WIDTH-1:0] z_rot
);

    logic             z_neg;
    logic [WIDTH-1:0] xs;
    logic [WIDTH-1:0] ys;

    assign z_neg = z[WIDTH-1];

    // Oversized shifts sign-fill to 0 or -1, which is the wanted behaviour.
    assign xs = $signed(x) >>> shift;
    assign ys = $signed(y) >>> shift;

    assign x_rot = z_neg ? (x + ys)    : (x - ys);
    assign y_rot = z_neg ? (y - xs)    : (y + xs);
    assign z_rot = z_neg ? (z + alpha) : (z - alpha);

endmodule

// File: rtl/cordic_iter_core.sv
// One CORDIC rotation iteration with registered x/y/z; an external controller
// sequences init/loop/shift/alpha for iterative or pipelined engines.
`timescale 1ns/1ps
module cordic_iter_core
    import cordic_pkg::*;
#(
    parameter  int WIDTH = 16,
    localparam int SHW   = (WIDTH > 2) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clkena,
    input  logic             init,
    input  logic             loop,
    input  logic [SHW-1:0]   shift,
    input  logic [WIDTH-1:0] alpha,
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_y,
    input  logic [WIDTH-1:0] i_z,
    output logic [WIDTH-1:0] o_x,
    output logic [WIDTH-1:0] o_y,
    output logic [WIDTH-1:0] o_z
);

    // Index 0 = x, 1 = y, 2 = z.
    logic [2:0][WIDTH-1:0] xyz_in;
    logic [2:0][WIDTH-1:0] xyz_reg;
    logic [2:0][WIDTH-1:0] xyz_src;
    logic [2:0][WIDTH-1:0] xyz_rot;
    logic [2:0][WIDTH-1:0] xyz_next;

    assign xyz_in = {i_z, i_y, i_x};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_coord
            // init bypasses the rotation, so the final mux sits after the adder.
            assign xyz_src[gi]  = loop ? xyz_reg[gi] : xyz_in[gi];
            assign xyz_next[gi] = init ? xyz_in[gi]  : xyz_rot[gi];
        end
    endgenerate

    cordic_rotate #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_rotate (
        .x     (xyz_src[0]),
        .y     (xyz_src[1]),
        .z     (xyz_src[2]),
        .shift (shift),
        .alpha (alpha),
        .x_rot (xyz_rot[0]),
        .y_rot (xyz_rot[1]),
        .z_rot (xyz_rot[2])
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            xyz_reg <= '0;
        end else if (clkena) begin
            xyz_reg <= xyz_next;
        end
    end

    assign o_x = xyz_reg[0];
    assign o_y = xyz_reg[1];
    assign o_z = xyz_reg[2];

endmodule

// File: tb/tb_cordic_iter_core.sv
// Directed-vector bench for cordic_iter_core at WIDTH=16 with hand-computed expectations.
`timescale 1ns/1ps
module tb_cordic_iter_core;

    logic        clk;
    logic        reset;
    logic        clkena;
    logic        init;
    logic        loop;
    logic [3:0]  shift;
    logic [15:0] alpha;
    logic [15:0] i_x;
    logic [15:0] i_y;
    logic [15:0] i_z;
    logic [15:0] o_x;
    logic [15:0] o_y;
    logic [15:0] o_z;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] atan_tab [15] = '{16'h2000, 16'h12E4, 16'h09FB, 16'h0511, 16'h028B,
                                   16'h0146, 16'h00A3, 16'h0051, 16'h0029, 16'h0014,
                                   16'h000A, 16'h0005, 16'h0003, 16'h0001, 16'h0001};

    cordic_iter_core #(.WIDTH(16)) dut (
        .clk    (clk),
        .reset  (reset),
        .clkena (clkena),
        .init   (init),
        .loop   (loop),
        .shift  (shift),
        .alpha  (alpha),
        .i_x    (i_x),
        .i_y    (i_y),
        .i_z    (i_z),
        .o_x    (o_x),
        .o_y    (o_y),
        .o_z    (o_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp,
                         input int tol = 0);
        int diff;
        n_checks++;
        diff = int'($signed(got)) - int'($signed(exp));
        if (diff < 0) diff = -diff;
        if (diff > tol) begin
            n_errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h (tol %0d)", tag, got, exp, tol);
        end else begin
            $display("ok   %s: 0x%04h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                         input logic [3:0] sh, input logic [15:0] al);
        i_x = x; i_y = y; i_z = z; shift = sh; alpha = al;
    endtask

    task automatic check_xyz(input string tag, input logic [15:0] ex, input logic [15:0] ey,
                             input logic [15:0] ez);
        check({tag, "_x"}, o_x, ex);
        check({tag, "_y"}, o_y, ey);
        check({tag, "_z"}, o_z, ez);
    endtask

    // Load (x0, 0, arg) then run 15 feedback iterations.
    task automatic run_sincos(input logic [15:0] arg);
        clkena = 1'b1; init = 1'b1; loop = 1'b0;
        drive(16'h4DB9, 16'h0000, arg, 4'd0, 16'h0000);
        tick();
        init = 1'b0; loop = 1'b1;
        for (int k = 0; k < 15; k++) begin
            drive(16'h5555, 16'hAAAA, 16'h7777, 4'(k), atan_tab[k]);
            tick();
        end
        loop = 1'b0;
    endtask

    initial begin
        reset = 1'b1; clkena = 1'b0; init = 1'b0; loop = 1'b0;
        drive(16'h0000, 16'h0000, 16'h0000, 4'd0, 16'h0000);
        #1 reset = 1'b0;
        #1;
        check_xyz("reset", 16'h0000, 16'h0000, 16'h0000);

        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // Disabled clock holds zeros even with init asserted.
        clkena = 1'b0; init = 1'b1;
        drive(16'h1234, 16'h5678, 16'h9ABC, 4'd0, 16'h0000);
        repeat (3) tick();
        check_xyz("hold_off", 16'h0000, 16'h0000, 16'h0000);

        clkena = 1'b1; init = 1'b1;
        drive(16'h4DB9, 16'h0000, 16'h2000, 4'd5, 16'h1111);
        tick();
        check_xyz("init", 16'h4DB9, 16'h0000, 16'h2000);

        init = 1'b0; loop = 1'b0;
        drive(16'h4000, 16'h0000, 16'h1000, 4'd0, 16'h2000);
        tick();
        check_xyz("pipe", 16'h4000, 16'h4000, 16'hF000);

        // Inputs are garbage: loop must use the registered state.
        loop = 1'b1;
        drive(16'h1111, 16'h2222, 16'h3333, 4'd1, 16'h12E4);
        tick();
        check_xyz("loop_neg", 16'h6000, 16'h2000, 16'h02E4);

        clkena = 1'b0; init = 1'b1;
        drive(16'hFFFF, 16'hFFFF, 16'hFFFF, 4'd7, 16'h7FFF);
        tick();
        check_xyz("hold_on", 16'h6000, 16'h2000, 16'h02E4);

        clkena = 1'b1; init = 1'b0; loop = 1'b0;
        drive(16'h0000, 16'h8000, 16'h0000, 4'd3, 16'h0000);
        tick();
        check_xyz("ashr3", 16'h1000, 16'h8000, 16'h0000);

        drive(16'h8000, 16'h0000, 16'h0000, 4'd15, 16'h0000);
        tick();
        check_xyz("ashr15", 16'h8000, 16'hFFFF, 16'h0000);

        drive(16'h1000, 16'h0800, 16'hF000, 4'd2, 16'h0100);
        tick();
        check_xyz("pipe_neg", 16'h1200, 16'h0400, 16'hF100);

        drive(16'h7FFF, 16'h7FFF, 16'h0000, 4'd0, 16'h8000);
        tick();
        check_xyz("wrap", 16'h0000, 16'hFFFE, 16'h8000);

        run_sincos(16'h2000);
        check("cos_p45", o_x, 16'h5A82, 3);
        check("sin_p45", o_y, 16'h5A82, 3);
        check("res_p45", o_z, 16'h0000, 3);

        run_sincos(16'hE000);
        check("cos_m45", o_x, 16'h5A82, 3);
        check("sin_m45", o_y, 16'hA57E, 3);

        // Abort a run part-way with an asynchronous reset.
        clkena = 1'b1; init = 1'b1; loop = 1'b0;
        drive(16'h4DB9, 16'h0000, 16'h2000, 4'd0, 16'h0000);
        tick();
        init = 1'b0; loop = 1'b1;
        drive(16'h0000, 16'h0000, 16'h0000, 4'd0, 16'h2000);
        tick();
        check("pre_abort_y", o_y, 16'h4DB9);
        #2 reset = 1'b0;
        #1;
        check_xyz("async_rst", 16'h0000, 16'h0000, 16'h0000);
        init = 1'b1;
        drive(16'h1234, 16'h5678, 16'h9ABC, 4'd0, 16'h0000);
        tick();
        check_xyz("rst_held", 16'h0000, 16'h0000, 16'h0000);
        reset = 1'b1; clkena = 1'b0;
        tick();
        check_xyz("post_rst", 16'h0000, 16'h0000, 16'h0000);
        clkena = 1'b1;
        tick();
        check_xyz("reload", 16'h1234, 16'h5678, 16'h9ABC);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
